// File: rtl/ddr_responder.sv
// ddr_responder: behavioural memory-side end of the core's single DDR channel.
// It serves one request at a time: a masked 64-bit write, a 64-bit read, or an
// 8-word (512-bit) instruction burst read. Data comes from an internal word
// array and completion is reported after a fixed latency.
// Optional feature macro: DDR_RESP_STALL_EN. When it is defined, an LFSR
// randomly withholds ddr_ready in idle cycles to emulate refresh and
// back-pressure.
module ddr_responder #(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ddr_chip_enable,
  input  logic [18:0]  ddr_index,
  input  logic         ddr_write_enable,
  input  logic         ddr_burst_mode,
  input  logic [63:0]  ddr_opstore_write_mask,
  input  logic [63:0]  ddr_opstore_write_data,
  output logic [63:0]  ddr_opload_read_data,
  output logic [511:0] ddr_pc_read_inst,
  output logic         ddr_operation_done,
  output logic         ddr_ready,
  output logic         protocol_error
);

  localparam int DEPTH = 1 << ADDR_BITS;

  // Number of BUSY cycles before DONE. A value of 0 means the request goes
  // straight from acceptance to DONE, which only happens when LATENCY is 1.
  localparam logic [4:0] SINGLE_LOAD = 5'(LATENCY - 1);
  localparam logic [4:0] BURST_LOAD  = 5'(LATENCY + 6);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                 state_q;
  logic [4:0]             cnt_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   we_q;
  logic                   burst_q;
  logic [63:0]            rdata_q;
  logic [511:0]           inst_q;
  logic                   done_q;
  logic                   ready_q;
  logic                   perr_q;

  logic [63:0]            mem_q [0:DEPTH-1];

  logic [ADDR_BITS-1:0]   idx_s;
  logic                   accept_s;
  logic                   req_burst_s;
  logic [4:0]             load_s;
  logic [ADDR_BITS-1:0]   rd_base_s;
  logic                   cur_we_s;
  logic                   cur_burst_s;
  logic [63:0]            single_word_s;
  logic [511:0]           burst_words_s;
  logic                   idle_ok_s;
  logic                   unused_idx_s;

  assign idx_s        = ddr_index[ADDR_BITS-1:0];
  assign unused_idx_s = ^ddr_index[18:ADDR_BITS];

  // ready_q is 1 only in IDLE, so this single test also qualifies the state.
  assign accept_s    = ddr_chip_enable & ready_q & ~reset;
  assign req_burst_s = ddr_burst_mode & ~ddr_write_enable;
  assign load_s      = req_burst_s ? BURST_LOAD : SINGLE_LOAD;

`ifdef DDR_RESP_STALL_EN
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Fibonacci LFSR next value, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Free-running LFSR; it advances every cycle and is reseeded by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // The LFSR value of the coming cycle decides whether ready may be offered.
  assign idle_ok_s = (lfsr_d[1:0] != 2'b00);
`else
  assign idle_ok_s = 1'b1;
`endif

  // Read address and request kind: taken from the live inputs when the
  // request completes on its own acceptance edge, otherwise from the latches.
  always_comb begin
    if (state_q == IDLE) begin
      rd_base_s   = idx_s;
      cur_we_s    = ddr_write_enable;
      cur_burst_s = req_burst_s;
    end else begin
      rd_base_s   = addr_q;
      cur_we_s    = we_q;
      cur_burst_s = burst_q;
    end
  end

  // Single word and eight consecutive words, wrapping at the top of the array.
  always_comb begin
    single_word_s = mem_q[rd_base_s];
    burst_words_s = '0;
    for (int k = 0; k < 8; k++) begin
      burst_words_s[64*k +: 64] = mem_q[rd_base_s + ADDR_BITS'(k)];
    end
  end

  // The write commits on the acceptance edge; reset never clears the array.
  always_ff @(posedge clock) begin
    if (accept_s && ddr_write_enable) begin
      mem_q[idx_s] <= (mem_q[idx_s] & ~ddr_opstore_write_mask) |
                      (ddr_opstore_write_data & ddr_opstore_write_mask);
    end
  end

  // Request FSM with registered ready, done, read-data and error outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      burst_q <= 1'b0;
      rdata_q <= 64'd0;
      inst_q  <= 512'd0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            addr_q  <= idx_s;
            we_q    <= ddr_write_enable;
            burst_q <= req_burst_s;
            ready_q <= 1'b0;
            cnt_q   <= load_s;
            if (load_s == 5'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              if (!cur_we_s) begin
                if (cur_burst_s) begin
                  inst_q <= burst_words_s;
                end else begin
                  rdata_q <= single_word_s;
                end
              end
            end else begin
              state_q <= BUSY;
              done_q  <= 1'b0;
            end
          end else begin
            ready_q <= idle_ok_s;
            done_q  <= 1'b0;
          end
        end
        BUSY: begin
          ready_q <= 1'b0;
          if (cnt_q <= 5'd1) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            cnt_q   <= 5'd0;
            if (!cur_we_s) begin
              if (cur_burst_s) begin
                inst_q <= burst_words_s;
              end else begin
                rdata_q <= single_word_s;
              end
            end
          end else begin
            cnt_q  <= cnt_q - 5'd1;
            done_q <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= idle_ok_s;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b0;
        end
      endcase
      // A strobe while not ready is dropped but remembered until reset.
      if (ddr_chip_enable && !ready_q) begin
        perr_q <= 1'b1;
      end
    end
  end

  assign ddr_opload_read_data = rdata_q;
  assign ddr_pc_read_inst     = inst_q;
  assign ddr_operation_done   = done_q;
  assign ddr_ready            = ready_q;
  assign protocol_error       = perr_q;

endmodule

// File: tb/tb_ddr_responder.sv
// Directed testbench for ddr_responder (ADDR_BITS=16, LATENCY=2).
module tb_ddr_responder;

  logic         clock;
  logic         reset;
  logic         ddr_chip_enable;
  logic [18:0]  ddr_index;
  logic         ddr_write_enable;
  logic         ddr_burst_mode;
  logic [63:0]  ddr_opstore_write_mask;
  logic [63:0]  ddr_opstore_write_data;
  logic [63:0]  ddr_opload_read_data;
  logic [511:0] ddr_pc_read_inst;
  logic         ddr_operation_done;
  logic         ddr_ready;
  logic         protocol_error;

  int n_total = 0;
  int n_bad   = 0;
  int done_cnt = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  ddr_responder #(.ADDR_BITS(16), .LATENCY(2)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .ddr_chip_enable        (ddr_chip_enable),
    .ddr_index              (ddr_index),
    .ddr_write_enable       (ddr_write_enable),
    .ddr_burst_mode         (ddr_burst_mode),
    .ddr_opstore_write_mask (ddr_opstore_write_mask),
    .ddr_opstore_write_data (ddr_opstore_write_data),
    .ddr_opload_read_data   (ddr_opload_read_data),
    .ddr_pc_read_inst       (ddr_pc_read_inst),
    .ddr_operation_done     (ddr_operation_done),
    .ddr_ready              (ddr_ready),
    .protocol_error         (protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count done pulses so an aborted operation can be shown to produce none.
  always @(posedge clock) begin
    if (ddr_operation_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge, measure latency to done, check that
  // ready drops after acceptance and returns the cycle after done. With poke
  // set, a stray write strobe to 0x10 is held during cycle T+1.
  task automatic do_req(input string tag, input logic we, input logic burst,
                        input logic [18:0] idx, input logic [63:0] mask,
                        input logic [63:0] data, input int exp_lat, input logic poke);
    int k;
    k = 0;
    while (ddr_ready !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    check_val({tag, "_ready_before"}, ddr_ready, 1);
    ddr_chip_enable        = 1'b1;
    ddr_write_enable       = we;
    ddr_burst_mode         = burst;
    ddr_index              = idx;
    ddr_opstore_write_mask = mask;
    ddr_opstore_write_data = data;
    @(posedge clock);
    @(negedge clock);
    check_val({tag, "_ready_T1"}, ddr_ready, 0);
    if (poke) begin
      ddr_write_enable       = 1'b1;
      ddr_burst_mode         = 1'b0;
      ddr_index              = 19'h00010;
      ddr_opstore_write_mask = ONES;
      ddr_opstore_write_data = 64'd0;
    end else begin
      ddr_chip_enable = 1'b0;
    end
    k = 1;
    while (ddr_operation_done !== 1'b1 && k <= 40) begin
      @(negedge clock);
      k++;
      ddr_chip_enable = 1'b0;
    end
    ddr_chip_enable = 1'b0;
    check_val({tag, "_latency"}, k, exp_lat);
    @(negedge clock);
    check_val({tag, "_done_once"}, ddr_operation_done, 0);
    check_val({tag, "_ready_after"}, ddr_ready, 1);
  endtask

  logic [511:0] burst_exp;
  int           done_before;

  initial begin
    reset                  = 1'b1;
    ddr_chip_enable        = 1'b0;
    ddr_index              = 19'd0;
    ddr_write_enable       = 1'b0;
    ddr_burst_mode         = 1'b0;
    ddr_opstore_write_mask = 64'd0;
    ddr_opstore_write_data = 64'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_ready", ddr_ready, 0);
    check_val("rst_done", ddr_operation_done, 0);
    check_val("rst_rdata", ddr_opload_read_data, 0);
    check_val("rst_inst", ddr_pc_read_inst, 0);
    check_val("rst_perr", protocol_error, 0);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_val("ready_after_rst", ddr_ready, 1);

    // Full write then read back.
    do_req("wr_full", 1'b1, 1'b0, 19'h00010, ONES, 64'h1122334455667788, 2, 1'b0);
    check_val("wr_full_rdata", ddr_opload_read_data, 0);
    do_req("rd_full", 1'b0, 1'b0, 19'h00010, 64'd0, 64'd0, 2, 1'b0);
    check_val("rd_full_data", ddr_opload_read_data, 64'h1122334455667788);
    check_val("rd_full_inst", ddr_pc_read_inst, 0);

    // Masked write over the low half.
    do_req("wr_mask", 1'b1, 1'b0, 19'h00010, 64'h00000000FFFFFFFF, 64'hAAAAAAAABBBBBBBB, 2, 1'b0);
    do_req("rd_mask", 1'b0, 1'b0, 19'h00010, 64'd0, 64'd0, 2, 1'b0);
    check_val("rd_mask_data", ddr_opload_read_data, 64'h11223344BBBBBBBB);

    // Words around the wrap point hold their own index.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = 16'hFFFC + 16'(i);
      do_req("wr_wrap", 1'b1, 1'b0, {3'b000, a}, ONES, {48'd0, a}, 2, 1'b0);
    end
    // Upper index bits are ignored: 0x7FFFC addresses word 0xFFFC.
    do_req("burst", 1'b0, 1'b1, 19'h7FFFC, 64'd0, 64'd0, 9, 1'b0);
    burst_exp = {64'd3, 64'd2, 64'd1, 64'd0, 64'hFFFF, 64'hFFFE, 64'hFFFD, 64'hFFFC};
    check_val("burst_inst", ddr_pc_read_inst, burst_exp);
    check_val("burst_rdata_kept", ddr_opload_read_data, 64'h11223344BBBBBBBB);

    // Single read of a wrapped-range word leaves the burst result alone.
    do_req("rd_w2", 1'b0, 1'b0, 19'h00002, 64'd0, 64'd0, 2, 1'b0);
    check_val("rd_w2_data", ddr_opload_read_data, 64'd2);
    check_val("rd_w2_inst_kept", ddr_pc_read_inst, burst_exp);

    // Stray strobe during BUSY: ignored, flags protocol_error.
    check_val("perr_clear", protocol_error, 0);
    do_req("poke", 1'b0, 1'b0, 19'h0FFFD, 64'd0, 64'd0, 2, 1'b1);
    check_val("poke_data", ddr_opload_read_data, 64'hFFFD);
    check_val("poke_perr", protocol_error, 1);
    do_req("rd_after_poke", 1'b0, 1'b0, 19'h00010, 64'd0, 64'd0, 2, 1'b0);
    check_val("poke_ignored", ddr_opload_read_data, 64'h11223344BBBBBBBB);
    check_val("perr_sticky", protocol_error, 1);

    // Reset at T+1 of a burst.
    ddr_chip_enable  = 1'b1;
    ddr_write_enable = 1'b0;
    ddr_burst_mode   = 1'b1;
    ddr_index        = 19'h00000;
    @(posedge clock);
    @(negedge clock);
    ddr_chip_enable = 1'b0;
    reset = 1'b1;
    done_before = done_cnt;
    @(posedge clock);
    @(negedge clock);
    check_val("mid_rst_done", ddr_operation_done, 0);
    check_val("mid_rst_ready", ddr_ready, 0);
    check_val("mid_rst_rdata", ddr_opload_read_data, 0);
    check_val("mid_rst_inst", ddr_pc_read_inst, 0);
    check_val("mid_rst_perr", protocol_error, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_val("mid_rst_ready_rel", ddr_ready, 1);
    repeat (12) @(negedge clock);
    check_val("mid_rst_no_done", done_cnt, done_before);
    check_val("mid_rst_ready_idle", ddr_ready, 1);
    do_req("rd_kept0", 1'b0, 1'b0, 19'h00010, 64'd0, 64'd0, 2, 1'b0);
    check_val("kept_0x10", ddr_opload_read_data, 64'h11223344BBBBBBBB);
    do_req("rd_kept1", 1'b0, 1'b0, 19'h0FFFF, 64'd0, 64'd0, 2, 1'b0);
    check_val("kept_0xffff", ddr_opload_read_data, 64'hFFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
